ex_wb_stage: RTL and testbench

- Execute/writeback pipeline register and writeback unit sitting directly downstream of the execute stage.
- Captures the execute stage's ALU result, flags and control each cycle.
- Selects the register-file write data from ALU result, data-memory read data or link PC.
- Maintains the architectural Z/N flag register, resolves branches/jumps, and counts retired instructions.

---
 rtl/ex_wb_stage.sv | 121 ++++++++++++
 tb/tb_ex_wb_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_wb_stage.sv
// Execute/writeback pipeline register and writeback unit: selects register-file
// write data, holds the architectural Z/N flags, resolves branches and counts retirements.
module ex_wb_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 6
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [DATA_W-1:0] ex_result,
   input  logic              ex_zero,
   input  logic              ex_neg,
   input  logic [DATA_W-1:0] ex_pc,
   input  logic [DATA_W-1:0] ex_target,
   input  logic              ex_reg_write,
   input  logic              ex_mem_to_reg,
   input  logic              ex_pc_to_reg,
   input  logic              ex_set_flags,
   input  logic              ex_brz,
   input  logic              ex_brn,
   input  logic              ex_jump,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wb_we,
   output logic [REG_AW-1:0] wb_waddr,
   output logic [DATA_W-1:0] wb_wdata,
   output logic              flag_z,
   output logic              flag_n,
   output logic              redirect,
   output logic [DATA_W-1:0] redirect_pc,
   output logic [DATA_W-1:0] retired
);

   logic              vld_p1;
   logic [REG_AW-1:0] rd_p1;
   logic [DATA_W-1:0] result_p1;
   logic              zero_p1;
   logic              neg_p1;
   logic [DATA_W-1:0] pc_p1;
   logic [DATA_W-1:0] target_p1;
   logic              reg_write_p1;
   logic              mem_to_reg_p1;
   logic              pc_to_reg_p1;
   logic              set_flags_p1;
   logic              brz_p1;
   logic              brn_p1;
   logic              jump_p1;
   logic              taken;

   // Link value wins over load data, load data over ALU result.
   function automatic logic [DATA_W-1:0] sel_wdata(
      input logic              pc_to_reg,
      input logic              mem_to_reg,
      input logic [DATA_W-1:0] pc,
      input logic [DATA_W-1:0] rdata,
      input logic [DATA_W-1:0] result
   );
      if (pc_to_reg)
         return pc + DATA_W'(1);
      else if (mem_to_reg)
         return rdata;
      else
         return result;
   endfunction

   // ---- EX -> WB boundary ----
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1        <= 1'b0;
         rd_p1         <= '0;
         result_p1     <= '0;
         zero_p1       <= 1'b0;
         neg_p1        <= 1'b0;
         pc_p1         <= '0;
         target_p1     <= '0;
         reg_write_p1  <= 1'b0;
         mem_to_reg_p1 <= 1'b0;
         pc_to_reg_p1  <= 1'b0;
         set_flags_p1  <= 1'b0;
         brz_p1        <= 1'b0;
         brn_p1        <= 1'b0;
         jump_p1       <= 1'b0;
         flag_z        <= 1'b0;
         flag_n        <= 1'b0;
         retired       <= '0;
      end else begin
         // A taken branch in WB squashes the instruction entering behind it.
         vld_p1        <= ex_valid & ~taken;
         rd_p1         <= ex_rd;
         result_p1     <= ex_result;
         zero_p1       <= ex_zero;
         neg_p1        <= ex_neg;
         pc_p1         <= ex_pc;
         target_p1     <= ex_target;
         reg_write_p1  <= ex_reg_write;
         mem_to_reg_p1 <= ex_mem_to_reg;
         pc_to_reg_p1  <= ex_pc_to_reg;
         set_flags_p1  <= ex_set_flags;
         brz_p1        <= ex_brz;
         brn_p1        <= ex_brn;
         jump_p1       <= ex_jump;
         if (vld_p1 && set_flags_p1) begin
            flag_z <= zero_p1;
            flag_n <= neg_p1;
         end
         if (vld_p1)
            retired <= retired + DATA_W'(1);
      end
   end

   // ---- WB combinational outputs ----
   // Branches see the flags held before this instruction's own flag update.
   assign taken       = vld_p1 & (jump_p1 | (brz_p1 & flag_z) | (brn_p1 & flag_n));
   assign redirect    = taken;
   assign redirect_pc = taken ? target_p1 : '0;
   assign wb_we       = vld_p1 & reg_write_p1;
   assign wb_waddr    = vld_p1 ? rd_p1 : '0;
   assign wb_wdata    = vld_p1 ? sel_wdata(pc_to_reg_p1, mem_to_reg_p1, pc_p1, mem_rdata, result_p1)
                               : '0;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed plus randomized bench for ex_wb_stage against an instruction-level model;
// a narrow 4-bit instance alongside exercises counter and PC wrap-around.
module tb_ex_wb_stage;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   logic        rst_n;
   logic        ex_valid, ex_zero, ex_neg, ex_reg_write, ex_mem_to_reg, ex_pc_to_reg;
   logic        ex_set_flags, ex_brz, ex_brn, ex_jump;
   logic [5:0]  ex_rd;
   logic [31:0] ex_result, ex_pc, ex_target, mem_rdata;

   logic        wb_we, flag_z, flag_n, redirect;
   logic [5:0]  wb_waddr;
   logic [31:0] wb_wdata, redirect_pc, retired;

   logic        s_we, s_fz, s_fn, s_red;
   logic [5:0]  s_waddr;
   logic [3:0]  s_wdata, s_rpc, s_ret;

   ex_wb_stage #(.DATA_W(32), .REG_AW(6)) dut (
      .clock(clock), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rd(ex_rd),
      .ex_result(ex_result), .ex_zero(ex_zero), .ex_neg(ex_neg), .ex_pc(ex_pc),
      .ex_target(ex_target), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_pc_to_reg(ex_pc_to_reg), .ex_set_flags(ex_set_flags), .ex_brz(ex_brz),
      .ex_brn(ex_brn), .ex_jump(ex_jump), .mem_rdata(mem_rdata),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .flag_z(flag_z),
      .flag_n(flag_n), .redirect(redirect), .redirect_pc(redirect_pc), .retired(retired)
   );

   ex_wb_stage #(.DATA_W(4), .REG_AW(6)) dut_small (
      .clock(clock), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rd(ex_rd),
      .ex_result(ex_result[3:0]), .ex_zero(ex_zero), .ex_neg(ex_neg), .ex_pc(ex_pc[3:0]),
      .ex_target(ex_target[3:0]), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_pc_to_reg(ex_pc_to_reg), .ex_set_flags(ex_set_flags), .ex_brz(ex_brz),
      .ex_brn(ex_brn), .ex_jump(ex_jump), .mem_rdata(mem_rdata[3:0]),
      .wb_we(s_we), .wb_waddr(s_waddr), .wb_wdata(s_wdata), .flag_z(s_fz),
      .flag_n(s_fn), .redirect(s_red), .redirect_pc(s_rpc), .retired(s_ret)
   );

   typedef struct {
      logic        v;
      logic [5:0]  rd;
      logic [31:0] res;
      logic        z, n;
      logic [31:0] pc, tgt;
      logic        rw, m2r, p2r, sf, brz, brn, jmp;
   } ins_t;

   int          checks = 0;
   int          passes = 0;
   ins_t        wb;
   logic        mz, mn;
   logic [31:0] mret, mrd;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic ins_t nop();
      ins_t i;
      i = '{v:1'b0, rd:6'd0, res:32'd0, z:1'b0, n:1'b0, pc:32'd0, tgt:32'd0,
            rw:1'b0, m2r:1'b0, p2r:1'b0, sf:1'b0, brz:1'b0, brn:1'b0, jmp:1'b0};
      return i;
   endfunction

   function automatic ins_t alu(input logic [5:0] rd, input logic [31:0] res,
                                input logic z, input logic n, input logic sf);
      ins_t i;
      i = nop();
      i.v = 1'b1; i.rd = rd; i.res = res; i.z = z; i.n = n; i.sf = sf; i.rw = 1'b1;
      i.pc = $urandom; i.tgt = $urandom;
      return i;
   endfunction

   function automatic ins_t br(input logic bz, input logic bn, input logic j,
                               input logic [31:0] tgt);
      ins_t i;
      i = nop();
      i.v = 1'b1; i.brz = bz; i.brn = bn; i.jmp = j; i.tgt = tgt; i.pc = $urandom;
      return i;
   endfunction

   function automatic ins_t rnd();
      ins_t i;
      i.v   = ($urandom_range(0, 3) != 0);
      i.rd  = 6'($urandom);
      i.res = $urandom; i.pc = $urandom; i.tgt = $urandom;
      i.z   = 1'($urandom); i.n = 1'($urandom);
      i.rw  = 1'($urandom); i.m2r = 1'($urandom);
      i.p2r = ($urandom_range(0, 3) == 0);
      i.sf  = 1'($urandom);
      i.brz = ($urandom_range(0, 5) == 0);
      i.brn = ($urandom_range(0, 5) == 0);
      i.jmp = ($urandom_range(0, 9) == 0);
      return i;
   endfunction

   task automatic drive(input ins_t i);
      ex_valid = i.v; ex_rd = i.rd; ex_result = i.res; ex_zero = i.z; ex_neg = i.n;
      ex_pc = i.pc; ex_target = i.tgt; ex_reg_write = i.rw; ex_mem_to_reg = i.m2r;
      ex_pc_to_reg = i.p2r; ex_set_flags = i.sf; ex_brz = i.brz; ex_brn = i.brn;
      ex_jump = i.jmp;
   endtask

   task automatic model_reset();
      wb = nop(); mz = 1'b0; mn = 1'b0; mret = 32'd0;
   endtask

   function automatic logic mtaken();
      return wb.v & (wb.jmp | (wb.brz & mz) | (wb.brn & mn));
   endfunction

   task automatic check_out();
      logic [31:0] ew;
      logic        t;
      t  = mtaken();
      ew = !wb.v ? 32'd0 : wb.p2r ? wb.pc + 32'd1 : wb.m2r ? mrd : wb.res;
      chk("wb_we", 64'(wb_we), 64'(wb.v & wb.rw));
      chk("wb_waddr", 64'(wb_waddr), 64'(wb.v ? wb.rd : 6'd0));
      chk("wb_wdata", 64'(wb_wdata), 64'(ew));
      chk("flag_z", 64'(flag_z), 64'(mz));
      chk("flag_n", 64'(flag_n), 64'(mn));
      chk("redirect", 64'(redirect), 64'(t));
      chk("redirect_pc", 64'(redirect_pc), 64'(t ? wb.tgt : 32'd0));
      chk("retired", 64'(retired), 64'(mret));
      chk("narrow_outputs", 64'({s_we, s_waddr, s_wdata, s_fz, s_fn, s_red, s_rpc, s_ret}),
          64'({wb.v & wb.rw, wb.v ? wb.rd : 6'd0, ew[3:0], mz, mn, t,
               t ? wb.tgt[3:0] : 4'd0, mret[3:0]}));
   endtask

   // Present one instruction, let it enter WB, then compare every output.
   task automatic cycle(input ins_t i, input logic [31:0] rd_data);
      logic t;
      drive(i);
      @(posedge clock);
      t = mtaken();
      if (wb.v) begin
         mret = mret + 32'd1;
         if (wb.sf) begin
            mz = wb.z;
            mn = wb.n;
         end
      end
      wb   = i;
      wb.v = i.v & ~t;
      #1;
      mrd       = rd_data;
      mem_rdata = rd_data;
      #1;
      check_out();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ins_t x;
      rst_n = 1'b1;
      mem_rdata = 32'd0;
      mrd = 32'd0;
      drive(alu(6'd5, 32'h1E, 1'b1, 1'b1, 1'b1));
      #3 rst_n = 1'b0;
      model_reset();
      #1 check_out();
      @(posedge clock);
      #2 check_out();
      @(negedge clock);
      rst_n = 1'b1;

      // ALU writeback and flag/retire update one edge later
      cycle(alu(6'd5, 32'h0000001E, 1'b0, 1'b0, 1'b1), 32'hDEAD);
      chk("alu_we", 64'(wb_we), 64'd1);
      chk("alu_wdata", 64'(wb_wdata), 64'h1E);
      cycle(nop(), 32'd0);
      chk("alu_retired", 64'(retired), 64'd1);

      x = alu(6'd3, 32'd2, 1'b0, 1'b0, 1'b0); x.m2r = 1'b1;
      cycle(x, 32'd19);
      chk("load_wdata", 64'(wb_wdata), 64'd19);

      x = alu(6'd7, 32'd99, 1'b0, 1'b0, 1'b0); x.p2r = 1'b1; x.pc = 32'h10;
      cycle(x, 32'd5);
      chk("savepc_wdata", 64'(wb_wdata), 64'h11);

      // SUB sets Z, brz follows immediately, third instruction is squashed
      cycle(alu(6'd1, 32'd0, 1'b1, 1'b0, 1'b1), 32'd0);
      cycle(br(1'b1, 1'b0, 1'b0, 32'h40), 32'd0);
      chk("brz_redirect", 64'(redirect), 64'd1);
      chk("brz_redirect_pc", 64'(redirect_pc), 64'h40);
      cycle(alu(6'd9, 32'h1234, 1'b0, 1'b1, 1'b1), 32'd0);
      chk("squash_we", 64'(wb_we), 64'd0);
      cycle(nop(), 32'd0);
      chk("squash_retired", 64'(retired), 64'd5);
      chk("squash_flag_n", 64'(flag_n), 64'd0);

      cycle(br(1'b0, 1'b1, 1'b0, 32'h77), 32'd0);
      chk("brn_not_taken", 64'(redirect), 64'd0);
      cycle(br(1'b0, 1'b0, 1'b1, 32'h8), 32'd0);
      chk("jump_redirect", 64'(redirect), 64'd1);
      chk("jump_redirect_pc", 64'(redirect_pc), 64'h8);
      cycle(alu(6'd2, 32'd1, 1'b0, 1'b0, 1'b0), 32'd0);
      chk("jump_squash_we", 64'(wb_we), 64'd0);
      chk("single_redirect", 64'(redirect), 64'd0);

      for (int k = 0; k < 300; k++)
         cycle(rnd(), $urandom);

      // Drive the narrow counter to all-ones, then one more retirement wraps it
      cycle(nop(), 32'd0);
      cycle(alu(6'd4, 32'd7, 1'b0, 1'b0, 1'b0), 32'd0);
      for (int k = 0; k < 20; k++) begin
         if (mret[3:0] == 4'hF) break;
         cycle(alu(6'd4, 32'd7, 1'b0, 1'b0, 1'b0), 32'd0);
      end
      chk("narrow_retired_max", 64'(s_ret), 64'hF);
      cycle(nop(), 32'd0);
      chk("narrow_retired_wrap", 64'(s_ret), 64'd0);

      x = alu(6'd8, 32'd1, 1'b0, 1'b0, 1'b0); x.p2r = 1'b1; x.pc = 32'h0000000F;
      cycle(x, 32'd0);
      chk("narrow_pc_wrap", 64'(s_wdata), 64'd0);

      // Asynchronous reset in the middle of a WB cycle
      cycle(alu(6'd4, 32'h55, 1'b1, 1'b1, 1'b1), 32'd0);
      chk("pre_reset_we", 64'(wb_we), 64'd1);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_we", 64'(wb_we), 64'd0);
      chk("async_retired", 64'(retired), 64'd0);
      check_out();
      @(posedge clock);
      #2 check_out();
      @(negedge clock);
      rst_n = 1'b1;
      cycle(alu(6'd6, 32'hAB, 1'b0, 1'b1, 1'b1), 32'd0);
      cycle(nop(), 32'd0);
      chk("post_reset_retired", 64'(retired), 64'd1);
      chk("post_reset_flag_n", 64'(flag_n), 64'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
